// File: rtl/key_packet_assembler_if.sv
// Packet handshake bundle between the key assembler and the buffer stage.
interface key_packet_assembler_if;
    logic [3:0] pkt_o;
    logic       pkt_valid_o;
    logic       pkt_ready_i;

    modport master (
        output pkt_o,
        output pkt_valid_o,
        input  pkt_ready_i
    );

    modport slave (
        input  pkt_o,
        input  pkt_valid_o,
        output pkt_ready_i
    );
endinterface

// File: rtl/key_packet_assembler.sv
// Debounced pushbutton front-end assembling 4-bit {dest, payload} packets.
// Optional macro KEY_PKT_AUTO_REARM_EN: re-enter COLLECT after each handshake.
module key_packet_assembler #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int PKT_BITS        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          key1,
    input  logic                          key2,
    key_packet_assembler_if.master        pkt,
    output logic                          busy_o,
    output logic [2:0]                    bit_cnt_o,
    output logic                          err_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t                state;
    logic [2:0]            raw;
    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            db;
    logic [2:0]            db_q;
    logic [DW-1:0]         dcnt [3];
    logic [PKT_BITS-1:0]   shreg;
    logic [TW-1:0]         tcnt;
    logic [2:0]            ev;
    logic                  start_ev;
    logic                  k1_ev;
    logic                  k2_ev;
    logic                  key_ev;
    logic                  conflict;
    logic                  accept;
    logic [PKT_BITS-1:0]   next_shreg;

    // Index 0 = start, 1 = key1, 2 = key2
    assign raw = {key2, key1, start};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db[i]) begin
                    if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]   <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    assign ev       = db & ~db_q;
    assign start_ev = ev[0];
    assign k1_ev    = ev[1];
    assign k2_ev    = ev[2];
    assign key_ev   = k1_ev | k2_ev;
    // A key press is only trusted while the other key is released
    assign conflict = (k1_ev & k2_ev) |
                      (k1_ev & db[2]) |
                      (k2_ev & db[1]);
    assign accept   = key_ev & ~conflict;
    assign next_shreg = {shreg[PKT_BITS-2:0], k1_ev};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            shreg           <= '0;
            tcnt            <= '0;
            bit_cnt_o       <= '0;
            busy_o          <= 1'b0;
            err_o           <= 1'b0;
            pkt.pkt_o       <= '0;
            pkt.pkt_valid_o <= 1'b0;
        end else begin
            err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ev) begin
                        state     <= COLLECT;
                        busy_o    <= 1'b1;
                        shreg     <= '0;
                        bit_cnt_o <= '0;
                        tcnt      <= '0;
                    end
                end
                COLLECT: begin
                    if (start_ev) begin
                        shreg     <= '0;
                        bit_cnt_o <= '0;
                        tcnt      <= '0;
                    end else if (accept) begin
                        shreg     <= next_shreg;
                        bit_cnt_o <= bit_cnt_o + 3'd1;
                        tcnt      <= '0;
                        if (bit_cnt_o == 3'(PKT_BITS - 1)) begin
                            pkt.pkt_o       <= next_shreg;
                            pkt.pkt_valid_o <= 1'b1;
                            state           <= HOLD;
                        end
                    end else begin
                        if (key_ev) begin
                            err_o <= 1'b1;
                        end
                        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            err_o     <= 1'b1;
                            state     <= IDLE;
                            busy_o    <= 1'b0;
                            bit_cnt_o <= '0;
                            tcnt      <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (pkt.pkt_valid_o && pkt.pkt_ready_i) begin
                        pkt.pkt_valid_o <= 1'b0;
                        bit_cnt_o       <= '0;
`ifdef KEY_PKT_AUTO_REARM_EN
                        state <= COLLECT;
                        shreg <= '0;
                        tcnt  <= '0;
`else
                        state  <= IDLE;
                        busy_o <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_packet_assembler.sv
// Directed bench for key_packet_assembler (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_key_packet_assembler;

`ifdef KEY_PKT_AUTO_REARM_EN
    localparam logic REARM = 1'b1;
`else
    localparam logic REARM = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       key1;
    logic       key2;
    logic       busy_o;
    logic [2:0] bit_cnt_o;
    logic       err_o;

    int n_assert;
    int n_fail;
    int valid_cycles;
    int accepts;
    int errs;

    key_packet_assembler_if bus ();

    key_packet_assembler #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64),
        .PKT_BITS        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key1      (key1),
        .key2      (key2),
        .pkt       (bus.master),
        .busy_o    (busy_o),
        .bit_cnt_o (bit_cnt_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.pkt_valid_o === 1'b1) valid_cycles++;
        if (bus.pkt_valid_o === 1'b1 && bus.pkt_ready_i === 1'b1) accepts++;
        if (err_o === 1'b1) errs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic val);
        case (which)
            0: start = val;
            1: key1 = val;
            default: key2 = val;
        endcase
    endtask

    // Clean press: long enough to debounce both the press and the release
    task automatic press(input int which);
        drive(which, 1'b1);
        repeat (8) tick();
        drive(which, 1'b0);
        repeat (8) tick();
    endtask

    int v0;
    int a0;
    int e0;

    initial begin
        n_assert = 0;
        n_fail = 0;
        valid_cycles = 0;
        accepts = 0;
        errs = 0;
        rst_n = 1'b0;
        start = 1'b0;
        key1 = 1'b0;
        key2 = 1'b0;
        bus.pkt_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_pkt", 32'(bus.pkt_o), 32'h0);
        chk("rst_valid", 32'(bus.pkt_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_bitcnt", 32'(bit_cnt_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: packet 1011 with downstream always ready
        bus.pkt_ready_i = 1'b1;
        e0 = errs;
        press(1);
        chk("t1_idle_key_ignored", 32'(bit_cnt_o), 32'h0);
        chk("t1_idle_busy", 32'(busy_o), 32'h0);
        press(0);
        chk("t1_busy", 32'(busy_o), 32'h1);
        chk("t1_cnt0", 32'(bit_cnt_o), 32'h0);
        press(1);
        chk("t1_cnt1", 32'(bit_cnt_o), 32'h1);
        press(2);
        chk("t1_cnt2", 32'(bit_cnt_o), 32'h2);
        press(1);
        chk("t1_cnt3", 32'(bit_cnt_o), 32'h3);
        v0 = valid_cycles;
        a0 = accepts;
        press(1);
        chk("t1_pkt", 32'(bus.pkt_o), 32'hB);
        chk("t1_valid_low", 32'(bus.pkt_valid_o), 32'h0);
        chk("t1_valid_cycles", 32'(valid_cycles - v0), 32'h1);
        chk("t1_accepts", 32'(accepts - a0), 32'h1);
        chk("t1_busy_after", 32'(busy_o), 32'(REARM));
        chk("t1_cnt_after", 32'(bit_cnt_o), 32'h0);
        chk("t1_no_err", 32'(errs - e0), 32'h0);

        // 2: packet 0000 held 20 cycles with ready low
        bus.pkt_ready_i = 1'b0;
        press(0);
        chk("t2_cnt0", 32'(bit_cnt_o), 32'h0);
        press(2);
        press(2);
        press(2);
        chk("t2_cnt3", 32'(bit_cnt_o), 32'h3);
        v0 = valid_cycles;
        a0 = accepts;
        e0 = errs;
        key2 = 1'b1;
        for (int i = 0; i < 20 && bus.pkt_valid_o !== 1'b1; i++) tick();
        chk("t2_valid_rise", 32'(bus.pkt_valid_o), 32'h1);
        key2 = 1'b0;
        for (int i = 2; i <= 21; i++) begin
            if (i == 2) key1 = 1'b1;
            if (i == 12) key1 = 1'b0;
            tick();
            if (i == 21) bus.pkt_ready_i = 1'b1;
            if (i == 11 || i == 21) begin
                chk("t2_hold_pkt", 32'(bus.pkt_o), 32'h0);
                chk("t2_hold_valid", 32'(bus.pkt_valid_o), 32'h1);
                chk("t2_hold_cnt", 32'(bit_cnt_o), 32'h4);
            end
        end
        tick();
        bus.pkt_ready_i = 1'b0;
        chk("t2_valid_low", 32'(bus.pkt_valid_o), 32'h0);
        chk("t2_valid_cycles", 32'(valid_cycles - v0), 32'd21);
        chk("t2_accepts", 32'(accepts - a0), 32'h1);
        chk("t2_no_err", 32'(errs - e0), 32'h0);
        chk("t2_pkt_kept", 32'(bus.pkt_o), 32'h0);
        chk("t2_busy_after", 32'(busy_o), 32'(REARM));
        repeat (8) tick();

        // 3: bouncing key1 gives one event 6 cycles after the stable edge
        press(0);
        chk("t3_cnt0", 32'(bit_cnt_o), 32'h0);
        e0 = errs;
        for (int i = 0; i < 4; i++) begin
            key1 = ~key1;
            repeat (2) tick();
        end
        chk("t3_bounce_none", 32'(bit_cnt_o), 32'h0);
        key1 = 1'b1;
        repeat (6) tick();
        chk("t3_before_event", 32'(bit_cnt_o), 32'h0);
        tick();
        chk("t3_after_event", 32'(bit_cnt_o), 32'h1);
        repeat (3) tick();
        key1 = 1'b0;
        repeat (8) tick();
        chk("t3_single_event", 32'(bit_cnt_o), 32'h1);
        chk("t3_no_err", 32'(errs - e0), 32'h0);

        // 4: timeout after two presses
        press(0);
        chk("t4_restart_cnt", 32'(bit_cnt_o), 32'h0);
        press(1);
        press(2);
        chk("t4_cnt2", 32'(bit_cnt_o), 32'h2);
        e0 = errs;
        repeat (40) tick();
        chk("t4_not_yet", 32'(busy_o), 32'h1);
        for (int i = 0; i < 40 && busy_o !== 1'b0; i++) tick();
        chk("t4_idle", 32'(busy_o), 32'h0);
        chk("t4_err_now", 32'(err_o), 32'h1);
        chk("t4_cnt_zero", 32'(bit_cnt_o), 32'h0);
        press(1);
        press(2);
        chk("t4_ignored_cnt", 32'(bit_cnt_o), 32'h0);
        chk("t4_ignored_busy", 32'(busy_o), 32'h0);
        chk("t4_err_once", 32'(errs - e0), 32'h1);

        // 5: conflicting press, then reset mid-packet
        press(0);
        key1 = 1'b1;
        repeat (8) tick();
        chk("t5_cnt1", 32'(bit_cnt_o), 32'h1);
        e0 = errs;
        press(2);
        chk("t5_conflict_err", 32'(errs - e0), 32'h1);
        chk("t5_cnt_kept", 32'(bit_cnt_o), 32'h1);
        key1 = 1'b0;
        repeat (8) tick();
        press(2);
        press(1);
        chk("t5_cnt3", 32'(bit_cnt_o), 32'h3);
        e0 = errs;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_pkt", 32'(bus.pkt_o), 32'h0);
        chk("t5_rst_valid", 32'(bus.pkt_valid_o), 32'h0);
        chk("t5_rst_busy", 32'(busy_o), 32'h0);
        chk("t5_rst_cnt", 32'(bit_cnt_o), 32'h0);
        chk("t5_rst_err", 32'(err_o), 32'h0);
        repeat (4) tick();
        chk("t5_rst_no_err", 32'(errs - e0), 32'h0);

`ifdef KEY_PKT_AUTO_REARM_EN
        // 6: back-to-back packets without a second start
        bus.pkt_ready_i = 1'b1;
        a0 = accepts;
        press(0);
        press(1);
        press(1);
        press(2);
        press(2);
        chk("t6_pkt1", 32'(bus.pkt_o), 32'hC);
        chk("t6_rearm_busy", 32'(busy_o), 32'h1);
        chk("t6_rearm_cnt", 32'(bit_cnt_o), 32'h0);
        press(2);
        press(1);
        press(2);
        press(1);
        chk("t6_pkt2", 32'(bus.pkt_o), 32'h5);
        chk("t6_accepts", 32'(accepts - a0), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_packet_assembler.md
Name: key_packet_assembler

Overview:
Upstream front-end for the four-destination packet buffer stage. Synchronises and debounces the start, key1 and key2 pushbuttons and turns a sequence of four key presses into one 4-bit packet: key1 = 1, key2 = 0, MSB first. Packet format is {dest[1:0], payload[1:0]}. The packet is handed downstream through a valid/ready handshake to the stage that routes it into buffer 1..4.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required before a debounced level changes (min 1)
TIMEOUT_CYCLES, 1024, idle cycles allowed between presses in COLLECT before the packet is aborted (min 2)
PKT_BITS, 4, bits per packet; fixed at 4 for the current downstream

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  raw pushbutton, active-high, arms packet collection
key1  input  1  raw pushbutton, active-high, enters bit 1
key2  input  1  raw pushbutton, active-high, enters bit 0
pkt_ready_i  input  1  downstream can accept the packet
pkt_o  output  4  assembled packet {dest, payload}
pkt_valid_o  output  1  pkt_o holds a complete packet
busy_o  output  1  high in COLLECT or HOLD
bit_cnt_o  output  3  bits collected so far in the current packet (0..4)
err_o  output  1  one-cycle pulse on an aborted packet or a rejected press

Behaviour:
- Reset: the block samples rst_n low on a clk edge, with priority over all other inputs. It then clears state to IDLE, sets pkt_o=0, pkt_valid_o=0, busy_o=0, bit_cnt_o=0, err_o=0, and zeroes all synchronisers, debounce counters, debounced levels and the timeout counter. This applies mid-packet as well; a partial packet is discarded with no err pulse.
- Input conditioning: each raw button passes through a 2-flop synchroniser.
- Debounce: each button has its own counter. The debounced level takes the synchronised value only after that value has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Press event: a one-cycle pulse on a 0->1 edge of the debounced level. Latency from a clean raw edge to the event is 2 + DEBOUNCE_CYCLES cycles.
- Key conflict: a key1 event while key2 is debounced-high (or the reverse), or key1 and key2 events in the same cycle, is rejected. A rejected press shifts no bit and pulses err_o.
- State IDLE: key events are ignored with no err. A start event moves to COLLECT with shreg=0, bit_cnt=0 and the timeout counter cleared.
- State COLLECT, bit entry: an accepted key event sets shreg <= {shreg[2:0], bit}, increments bit_cnt and clears the timeout counter.
- State COLLECT, fourth bit: on the event that makes bit_cnt=4, the next edge loads pkt_o=shreg (including the new bit), sets pkt_valid_o=1 and moves to HOLD. bit_cnt_o reads 4 in HOLD.
- State COLLECT, restart: a start event clears shreg and bit_cnt and stays in COLLECT.
- State COLLECT, timeout: the timeout counter increments every cycle without an accepted key event. When it reaches TIMEOUT_CYCLES-1, the block pulses err_o for one cycle, sets bit_cnt to 0 and returns to IDLE.
- State COLLECT, start and key together: if a start event and a key event occur in the same cycle, start wins and the key is dropped.
- State HOLD: pkt_o and pkt_valid_o stay stable until pkt_valid_o && pkt_ready_i at a clk edge. That edge clears pkt_valid_o and bit_cnt and returns to IDLE. pkt_o keeps its last value.
- HOLD, inputs ignored: key and start events in HOLD are ignored with no err. There is no timeout in HOLD.
- pkt_ready_i is don't-care outside HOLD. The packet is never dropped and never duplicated.
- busy_o = (state != IDLE), registered.

Optional Feature:
KEY_PKT_AUTO_REARM_EN
- Defined: the handshake in HOLD moves to COLLECT instead of IDLE, with shreg, bit_cnt and the timeout counter cleared. Consecutive packets then need no start press, and the timeout still returns the block to IDLE.
- Undefined: the block behaves as specified above (returns to IDLE).

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
1. Reset, then start press, then clean presses key1,key2,key1,key1 with pkt_ready_i=1 -> pkt_o=4'b1011, pkt_valid_o high exactly 1 cycle, then IDLE with busy_o=0.
2. Start press, then key2 x4 with pkt_ready_i=0 for 20 cycles, then 1 -> pkt_o=4'b0000 held stable, pkt_valid_o high for 21 cycles, accepted once. Extra key1 presses during HOLD change nothing and pulse no err.
3. key1 raw bounces 1-0-1-0 every 2 cycles, then stable high 10 cycles -> exactly one event, fired 6 cycles after the stable edge; bit_cnt_o goes 0->1.
4. Start, then two presses, then no input for 64 cycles -> err_o pulses once, bit_cnt_o=0, state IDLE. Key presses afterwards are ignored until the next start.
5. key1 held debounced-high, then a key2 press -> err_o pulse, bit_cnt unchanged. Also assert rst_n=0 for 1 cycle after 3 bits -> all outputs 0, no err.
6. With KEY_PKT_AUTO_REARM_EN defined: packet 4'b1100 accepted, then immediate presses key2,key1,key2,key1 with no start -> second packet 4'b0101.
